// File: rtl/timer_count_ctrl_pkg.sv
// Shared definitions for the system timer: FSM states, divider limits, TCR field
// positions and the register map used by the register file.
package timer_pkg;

    localparam int CNT_WIDTH  = 64;
    localparam int DIV_WIDTH  = 4;
    localparam int DIV_MAX    = 8;
    localparam int PCNT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } timer_state_t;

    localparam int TCR_EN_BIT      = 0;
    localparam int TCR_DIV_EN_BIT  = 1;
    localparam int TCR_DIV_VAL_LSB = 8;
    localparam int TCR_DIV_VAL_MSB = 11;

    localparam logic [11:0] TCR_OFFSET   = 12'h000;
    localparam logic [11:0] TDR0_OFFSET  = 12'h004;
    localparam logic [11:0] TDR1_OFFSET  = 12'h008;
    localparam logic [11:0] TCMP0_OFFSET = 12'h00C;
    localparam logic [11:0] TCMP1_OFFSET = 12'h010;
    localparam logic [11:0] TIER_OFFSET  = 12'h014;
    localparam logic [11:0] TISR_OFFSET  = 12'h018;
    localparam logic [11:0] THCSR_OFFSET = 12'h01C;

    // Reserved divider codes above DIV_MAX saturate rather than wrap.
    function automatic logic [DIV_WIDTH-1:0] eff_exp(input logic div_en,
                                                     input logic [DIV_WIDTH-1:0] div_val);
        if (!div_en)
            return '0;
        if (div_val > DIV_WIDTH'(DIV_MAX))
            return DIV_WIDTH'(DIV_MAX);
        return div_val;
    endfunction

endpackage

// File: rtl/timer_count_ctrl_if.sv
// Control/status bundle between the timer register file (master) and the
// counter sequencer (slave).
interface timer_count_ctrl_if
    import timer_pkg::*;
();
    logic                  timer_en;
    logic                  div_en;
    logic [DIV_WIDTH-1:0]  div_val;
    logic [CNT_WIDTH-1:0]  tcmp;
    logic                  int_en;
    logic                  tisr_flag;
    logic                  halt_req;
    logic                  dbg_mode;
    logic                  tdr0_wr;
    logic                  tdr1_wr;
    logic [31:0]           wdata;
    logic [CNT_WIDTH-1:0]  mtime;
    logic                  int_pending_set;
    logic                  halt_ack;
    logic                  tim_int;
    timer_state_t          state;

    // Halt handshake: (halt_req & dbg_mode) is the request level; halt_ack rises on
    // the edge that freezes the counter and stays high exactly while frozen.
    modport master (
        output timer_en, div_en, div_val, tcmp, int_en, tisr_flag,
               halt_req, dbg_mode, tdr0_wr, tdr1_wr, wdata,
        input  mtime, int_pending_set, halt_ack, tim_int, state
    );

    modport slave (
        input  timer_en, div_en, div_val, tcmp, int_en, tisr_flag,
               halt_req, dbg_mode, tdr0_wr, tdr1_wr, wdata,
        output mtime, int_pending_set, halt_ack, tim_int, state
    );
endinterface

// File: rtl/timer_count_ctrl_prescaler.sv
// Power-of-two prescaler: tick fires once every 2^e run cycles; clr restarts the period.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_WIDTH-1:0] e,
    input  logic                 run,
    input  logic                 clr,
    output logic                 tick
);
    logic [PCNT_WIDTH-1:0] pcnt;
    logic [PCNT_WIDTH:0]   span;
    logic [PCNT_WIDTH-1:0] pmask;

    assign span  = (PCNT_WIDTH+1)'(1) << e;
    assign pmask = PCNT_WIDTH'(span - (PCNT_WIDTH+1)'(1));
    // A clearing cycle never ticks, so a restart always yields a full new period.
    assign tick  = run & ~clr & (pcnt == pmask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pcnt <= '0;
        else if (clr || tick)
            pcnt <= '0;
        else if (run)
            pcnt <= pcnt + PCNT_WIDTH'(1);
    end
endmodule

// File: rtl/timer_count_ctrl.sv
// System-timer counter sequencer: IDLE/RUN/HALT control, prescaled 64-bit mtime,
// TDR loads, compare-match set and interrupt output.
module timer_count_ctrl
    import timer_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    timer_count_ctrl_if.slave bus
);
    timer_state_t          state;
    logic                  halt_ack;
    logic                  halt_cond;
    logic                  run;
    logic                  clr;
    logic                  tick;
    logic                  tdr_wr;
    logic                  div_chg;
    logic                  div_en_q;
    logic [DIV_WIDTH-1:0]  div_val_q;
    logic [DIV_WIDTH-1:0]  exp_e;
    logic [CNT_WIDTH-1:0]  mtime;
    logic                  int_pending_set;
    logic                  tim_int;

    assign halt_cond = bus.halt_req & bus.dbg_mode;
    assign tdr_wr    = bus.tdr0_wr | bus.tdr1_wr;
    assign div_chg   = (bus.div_en != div_en_q) | (bus.div_val != div_val_q);
    assign exp_e     = eff_exp(bus.div_en, bus.div_val);
    // The halting edge itself must not count, hence the gate on halt_cond.
    assign run       = (state == RUN) & ~halt_cond;
    assign clr       = (state == IDLE) | div_chg | tdr_wr;

    timer_prescaler u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .e     (exp_e),
        .run   (run),
        .clr   (clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            halt_ack <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (halt_cond) begin
                        state    <= HALT;
                        halt_ack <= 1'b1;
                    end else if (bus.timer_en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (halt_cond) begin
                        state    <= HALT;
                        halt_ack <= 1'b1;
                    end else if (!bus.timer_en) begin
                        state <= IDLE;
                    end
                end
                HALT: begin
                    if (!halt_cond) begin
                        state    <= bus.timer_en ? RUN : IDLE;
                        halt_ack <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    halt_ack <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime           <= '0;
            int_pending_set <= 1'b0;
            tim_int         <= 1'b0;
            div_en_q        <= 1'b0;
            div_val_q       <= DIV_WIDTH'(1);
        end else begin
            // Software loads take priority over a same-cycle increment.
            if (tdr_wr) begin
                if (bus.tdr0_wr)
                    mtime[31:0] <= bus.wdata;
                if (bus.tdr1_wr)
                    mtime[63:32] <= bus.wdata;
            end else if (tick) begin
                mtime <= mtime + CNT_WIDTH'(1);
            end
            int_pending_set <= (mtime == bus.tcmp);
            tim_int         <= bus.tisr_flag & bus.int_en;
            div_en_q        <= bus.div_en;
            div_val_q       <= bus.div_val;
        end
    end

    assign bus.mtime           = mtime;
    assign bus.int_pending_set = int_pending_set;
    assign bus.halt_ack        = halt_ack;
    assign bus.tim_int         = tim_int;
    assign bus.state           = state;
endmodule
